// File: rtl/umai_mst_arbiter.sv
// umai_mst_arbiter
//   Shares one downstream UMAI master port between two upstream requesters
//   (the two aib_top channel groups). Write and read commands each have
//   their own round-robin arbiter. Write data follows the granted write
//   command. Read data goes back, in order, to the requester that issued the
//   read. A tag FIFO records {src, len} for each outstanding read burst.
//
// Ports
//   i_ip_clk, i_rst_n              clock, async active-low reset
//   i_req_wcmd_* / o_req_wcmd_ready  per-requester write command [1:0]
//   i_req_rcmd_* / o_req_rcmd_ready  per-requester read command [1:0]
//   i_req_w* / o_req_wready          per-requester write data [1:0]
//   o_req_r* / i_req_rready          per-requester read data [1:0]
//   o_wcmd_* / i_wcmd_ready          downstream write command
//   o_rcmd_* / i_rcmd_ready          downstream read command
//   o_w* / i_wready                  downstream write data
//   i_r* / o_rready                  downstream read data

// Two-requester round-robin arbiter. The grant is held from the first cycle
// valid is shown downstream until the handshake completes.
module umai_mst_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_en,
  input  logic       i_ready,
  output logic       o_gnt,
  output logic       o_valid,
  output logic       o_hs
);
  logic lp, lock, gnt_q, pick;

  always_comb begin
    pick = 1'b0;
    if (i_valid == 2'b11) pick = ~lp;
    else if (i_valid[1])  pick = 1'b1;
  end

  assign o_gnt   = lock ? gnt_q : pick;
  assign o_valid = i_en & i_valid[o_gnt];
  assign o_hs    = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lp    <= 1'b1;
      lock  <= 1'b0;
      gnt_q <= 1'b0;
    end else if (o_hs) begin
      lp    <= o_gnt;
      lock  <= 1'b0;
    end else if (o_valid) begin
      lock  <= 1'b1;
      gnt_q <= o_gnt;
    end
  end
endmodule

module umai_mst_arbiter #(
  parameter int AddrWidth     = 32,
  parameter int LenWidth      = 6,
  parameter int DataWidth     = 512,
  parameter int RdOutstanding = 4
) (
  input  logic                           i_ip_clk,
  input  logic                           i_rst_n,
  input  logic [1:0]                     i_req_wcmd_valid,
  output logic [1:0]                     o_req_wcmd_ready,
  input  logic [1:0][AddrWidth-1:0]      i_req_wcmd_addr,
  input  logic [1:0][LenWidth-1:0]       i_req_wcmd_len,
  input  logic [1:0]                     i_req_rcmd_valid,
  output logic [1:0]                     o_req_rcmd_ready,
  input  logic [1:0][AddrWidth-1:0]      i_req_rcmd_addr,
  input  logic [1:0][LenWidth-1:0]       i_req_rcmd_len,
  input  logic [1:0]                     i_req_wvalid,
  output logic [1:0]                     o_req_wready,
  input  logic [1:0][DataWidth-1:0]      i_req_wdata,
  output logic [1:0]                     o_req_rvalid,
  input  logic [1:0]                     i_req_rready,
  output logic [1:0][DataWidth-1:0]      o_req_rdata,
  output logic                           o_wcmd_valid,
  input  logic                           i_wcmd_ready,
  output logic [AddrWidth-1:0]           o_wcmd_addr,
  output logic [LenWidth-1:0]            o_wcmd_len,
  output logic                           o_rcmd_valid,
  input  logic                           i_rcmd_ready,
  output logic [AddrWidth-1:0]           o_rcmd_addr,
  output logic [LenWidth-1:0]            o_rcmd_len,
  output logic                           o_wvalid,
  input  logic                           i_wready,
  output logic [DataWidth-1:0]           o_wdata,
  input  logic                           i_rvalid,
  output logic                           o_rready,
  input  logic [DataWidth-1:0]           i_rdata
);
  localparam int PW = $clog2(RdOutstanding);
  localparam logic [LenWidth-1:0] LEN_ONE = LenWidth'(1);
  localparam logic [PW:0]         PTR_ONE = (PW+1)'(1);

  typedef enum logic {W_IDLE, W_DATA} w_state_t;

  // Holds every path off for the first cycle after reset release.
  logic rst_done;
  always_ff @(posedge i_ip_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  // ---------------- command arbiters (0: write, 1: read) ----------------
  logic            w_en, r_en, wgnt, rgnt, wcmd_hs, rcmd_hs;
  logic [1:0][1:0] cmd_vld;
  logic [1:0]      cmd_en, cmd_rdy, cmd_gnt, cmd_val, cmd_hs;

  assign cmd_vld = {i_req_rcmd_valid, i_req_wcmd_valid};
  assign cmd_en  = {r_en, w_en};
  assign cmd_rdy = {i_rcmd_ready, i_wcmd_ready};

  for (genvar c = 0; c < 2; c++) begin : g_arb
    umai_mst_rr_arb u_arb (
      .i_clk   (i_ip_clk),
      .i_rst_n (i_rst_n),
      .i_valid (cmd_vld[c]),
      .i_en    (cmd_en[c]),
      .i_ready (cmd_rdy[c]),
      .o_gnt   (cmd_gnt[c]),
      .o_valid (cmd_val[c]),
      .o_hs    (cmd_hs[c])
    );
  end

  assign wgnt    = cmd_gnt[0];
  assign rgnt    = cmd_gnt[1];
  assign wcmd_hs = cmd_hs[0];
  assign rcmd_hs = cmd_hs[1];

  assign o_wcmd_valid = cmd_val[0];
  assign o_wcmd_addr  = i_req_wcmd_addr[wgnt];
  assign o_wcmd_len   = i_req_wcmd_len[wgnt];
  assign o_rcmd_valid = cmd_val[1];
  assign o_rcmd_addr  = i_req_rcmd_addr[rgnt];
  assign o_rcmd_len   = i_req_rcmd_len[rgnt];

  for (genvar i = 0; i < 2; i++) begin : g_req
    assign o_req_wcmd_ready[i] = i_wcmd_ready & w_en & (wgnt == 1'(i));
    assign o_req_rcmd_ready[i] = i_rcmd_ready & r_en & (rgnt == 1'(i));
  end

  // ---------------- write data FSM ----------------
  w_state_t            w_st, w_nxt;
  logic                wsrc;
  logic [LenWidth-1:0] wcnt;
  logic                w_beat;

  assign w_beat = o_wvalid & i_wready;

  always_ff @(posedge i_ip_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_st <= W_IDLE;
      wsrc <= 1'b0;
      wcnt <= '0;
    end else begin
      w_st <= w_nxt;
      if (wcmd_hs) begin
        wsrc <= wgnt;
        wcnt <= o_wcmd_len;
      end else if (w_beat) begin
        wcnt <= wcnt - LEN_ONE;
      end
    end
  end

  always_comb begin
    w_nxt        = w_st;
    w_en         = 1'b0;
    o_wvalid     = 1'b0;
    o_req_wready = '0;
    o_wdata      = i_req_wdata[wsrc];
    case (w_st)
      W_IDLE: begin
        w_en = rst_done;
        if (wcmd_hs) w_nxt = W_DATA;
      end
      W_DATA: begin
        o_wvalid           = i_req_wvalid[wsrc];
        o_req_wready[wsrc] = i_wready;
        if (i_req_wvalid[wsrc] && i_wready && wcnt == '0) w_nxt = W_IDLE;
      end
      default: w_nxt = W_IDLE;
    endcase
  end

  // ---------------- read tag FIFO ----------------
  // Entry = {src, len}; the extra pointer bit distinguishes full from empty.
  logic [RdOutstanding-1:0][LenWidth:0] fifo;
  logic [PW:0]                          wp, rp;
  logic                                 full, empty, h_src, r_beat, r_pop;
  logic [LenWidth-1:0]                  h_len, rcnt;

  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign r_en  = rst_done & ~full;   // full blocks even when a pop is in flight
  assign h_src = fifo[rp[PW-1:0]][LenWidth];
  assign h_len = fifo[rp[PW-1:0]][LenWidth-1:0];

  assign o_rready    = ~empty & i_req_rready[h_src];
  assign r_beat      = i_rvalid & o_rready;
  assign r_pop       = r_beat & (rcnt == h_len);
  assign o_req_rdata = {i_rdata, i_rdata};

  always_comb begin
    o_req_rvalid = '0;
    if (!empty) o_req_rvalid[h_src] = i_rvalid;
  end

  always_ff @(posedge i_ip_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo <= '0;
      wp   <= '0;
      rp   <= '0;
      rcnt <= '0;
    end else begin
      if (rcmd_hs) begin
        fifo[wp[PW-1:0]] <= {rgnt, o_rcmd_len};
        wp               <= wp + PTR_ONE;
      end
      if (r_pop) begin
        rp   <= rp + PTR_ONE;
        rcnt <= '0;
      end else if (r_beat) begin
        rcnt <= rcnt + LEN_ONE;
      end
    end
  end
endmodule
